// File: rtl/frame_pkg.sv
// Shared state encoding and default frame geometry for the frame serializer slice.
package frame_pkg;
    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned SYNC_W_DEF = 8;
    localparam logic [SYNC_W_DEF-1:0] SYNC_PAT_DEF = 8'b1110_0100;
    localparam int unsigned FRAME_BITS = SYNC_W_DEF + DATA_W_DEF + 1;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        PARITY,
        GAP
    } state_t;
endpackage

// File: rtl/bit_timer.sv
// Per-bit divider: counts DIV enabled cycles per serial bit and decodes the strobes the FSM acts on.
// bit_end marks the last cycle of a bit; mid_tick and pre_end mark the cycle before mid-bit / last cycle.
module bit_timer #(
    parameter int unsigned DIV = 4
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic run,
    input  logic restart,
    output logic bit_end,
    output logic mid_tick,
    output logic pre_end
);
    localparam int unsigned CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || restart) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= bit_end ? '0 : cnt + CNT_W'(1);
        end
    end

    assign bit_end  = (cnt == CNT_W'(DIV - 1));
    assign mid_tick = (cnt == CNT_W'(DIV / 2 - 1));
    assign pre_end  = (cnt == CNT_W'(DIV - 2));
endmodule

// File: rtl/frame_serializer.sv
// Frames a payload as sync header + payload (MSB first) + even parity on a slow serial line.
// Optional FRAME_SERIALIZER_ERR_INJECT_EN adds err_inject, which inverts the next parity bit sent.
module frame_serializer
    import frame_pkg::*;
#(
    parameter int unsigned DIV      = 5000000,
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned SYNC_W   = SYNC_W_DEF,
    parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEF,
    parameter int unsigned GAP_BITS = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              enable,
    input  logic              load,
    input  logic [DATA_W-1:0] payload,
`ifdef FRAME_SERIALIZER_ERR_INJECT_EN
    input  logic              err_inject,
`endif
    output logic              ready,
    output logic              busy,
    output logic              serial_data,
    output logic              bit_tick,
    output logic              frame_done,
    output logic [7:0]        frame_cnt
);
    localparam int unsigned FRM_W = SYNC_W + DATA_W + 1;
    localparam int unsigned IDX_W = $clog2(FRM_W + GAP_BITS);

    state_t           state;
    logic [IDX_W-1:0] bit_idx;
    logic [FRM_W-1:0] shreg;
    logic             run;
    logic             restart;
    logic             bit_end;
    logic             mid_tick;
    logic             pre_end;
    logic             par_flip;

    assign run     = enable & busy;
    assign restart = enable & ready & load;

    bit_timer #(.DIV(DIV)) u_bit_timer (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .run      (run),
        .restart  (restart),
        .bit_end  (bit_end),
        .mid_tick (mid_tick),
        .pre_end  (pre_end)
    );

`ifdef FRAME_SERIALIZER_ERR_INJECT_EN
    // One-shot: armed by a pulse, consumed by the frame whose parity bit it inverted.
    logic armed;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            armed <= 1'b0;
        end else if (err_inject) begin
            armed <= 1'b1;
        end else if (enable && state == PARITY && pre_end) begin
            armed <= 1'b0;
        end
    end

    assign par_flip = armed;
`else
    assign par_flip = 1'b0;
`endif

    // Frame FSM; shreg holds the whole frame so the line always takes its MSB-next bit.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            bit_idx     <= '0;
            shreg       <= '0;
            ready       <= 1'b1;
            busy        <= 1'b0;
            serial_data <= 1'b0;
            bit_tick    <= 1'b0;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            bit_tick   <= 1'b0;
            frame_done <= 1'b0;
            if (enable) begin
                if (state == IDLE) begin
                    if (load) begin
                        shreg       <= {SYNC_PAT, payload, ^payload};
                        serial_data <= SYNC_PAT[SYNC_W-1];
                        bit_idx     <= '0;
                        state       <= SYNC;
                        ready       <= 1'b0;
                        busy        <= 1'b1;
                    end
                end else begin
                    if (mid_tick && state != GAP) begin
                        bit_tick <= 1'b1;
                    end
                    if (pre_end && state == PARITY) begin
                        frame_done <= 1'b1;
                        frame_cnt  <= frame_cnt + 8'd1;
                    end
                    if (bit_end) begin
                        bit_idx <= bit_idx + IDX_W'(1);
                        shreg   <= {shreg[FRM_W-2:0], 1'b0};
                        case (state)
                            SYNC: begin
                                serial_data <= shreg[FRM_W-2];
                                if (bit_idx == IDX_W'(SYNC_W - 1)) begin
                                    state   <= DATA;
                                    bit_idx <= '0;
                                end
                            end
                            DATA: begin
                                if (bit_idx == IDX_W'(DATA_W - 1)) begin
                                    serial_data <= shreg[FRM_W-2] ^ par_flip;
                                    state       <= PARITY;
                                    bit_idx     <= '0;
                                end else begin
                                    serial_data <= shreg[FRM_W-2];
                                end
                            end
                            PARITY: begin
                                serial_data <= 1'b0;
                                state       <= GAP;
                                bit_idx     <= '0;
                            end
                            default: begin
                                if (bit_idx == IDX_W'(GAP_BITS - 1)) begin
                                    state   <= IDLE;
                                    bit_idx <= '0;
                                    ready   <= 1'b1;
                                    busy    <= 1'b0;
                                end
                            end
                        endcase
                    end
                end
            end
        end
    end
endmodule
